// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and receiver.
//   - state_e       : host transmitter FSM states
//   - ERR_*         : err_code values reported with the err pulse
//   - PS2_*         : default timing, in 50 MHz clk cycles
//   - frame_bit()   : level the host drives after the n-th device falling edge
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        WAIT_IDLE,
        ERR
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_EDGE  = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    localparam int PS2_INHIBIT_CYCLES = 5000;    // 100 us
    localparam int PS2_START_TIMEOUT  = 750000;  // 15 ms
    localparam int PS2_EDGE_TIMEOUT   = 10000;   // 200 us

    // After fall n: n = 1..8 -> data bit n-1 (LSB first), n = 9 -> parity,
    // anything else -> stop bit, i.e. the line released.
    function automatic logic frame_bit(input logic [7:0] data,
                                       input logic       parity,
                                       input logic [3:0] n);
        logic [2:0] idx;
        logic       b;
        idx = 3'(n - 4'd1);
        b   = 1'b1;
        if (n >= 4'd1 && n <= 4'd8) begin
            b = data[idx];
        end else if (n == 4'd9) begin
            b = parity;
        end
        return b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings one raw open-drain PS/2 pin into the clk domain.
//   clk, rst : system clock, asynchronous active-high reset
//   pin      : raw pin level (asynchronous)
//   sync     : pin after a 2-flop synchronizer
//   fall     : one-cycle high when sync goes 1 -> 0 (prev & ~sync)
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = pin;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: reset to 1, the released bus level, so leaving reset can
            // never look like a falling edge.
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter for one command byte.
//   clk, rst            : 50 MHz system clock, asynchronous active-high reset
//   tx_data, tx_valid   : byte to send; accepted when tx_valid && tx_ready
//   tx_ready / busy     : high only in IDLE / high outside IDLE
//   done / err          : one-cycle pulses; err_code (01 start timeout,
//                         10 edge timeout, 11 no ACK) holds its last value
//   ps2_clk_in/data_in  : raw pin levels
//   ps2_clk_oe/data_oe  : 1 = pull the open-drain line low (registered)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
    parameter int EDGE_TIMEOUT   = PS2_EDGE_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAX_T = (START_TIMEOUT > EDGE_TIMEOUT)
                         ? ((START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES)
                         : ((EDGE_TIMEOUT > INHIBIT_CYCLES) ? EDGE_TIMEOUT : INHIBIT_CYCLES);
    localparam int CNT_W = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] EDGE_LAST  = CNT_W'(EDGE_TIMEOUT - 1);

    logic clk_sync, clk_fall;
    logic data_sync, data_fall_unused;  // data line is only sampled by level

    ps2_line_sync u_clk_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (ps2_clk_in),
        .sync (clk_sync),
        .fall (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (ps2_data_in),
        .sync (data_sync),
        .fall (data_fall_unused)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       n_q, n_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             abort;
    logic [1:0]       abort_code;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // value unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        data_d     = data_q;
        parity_d   = parity_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        abort      = 1'b0;
        abort_code = ERR_NONE;

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    data_d   = tx_data;
                    parity_d = ~^tx_data;
                    cnt_d    = '0;
                    n_d      = 4'd0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    // Clock release and start bit change on the same edge.
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REQ: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    n_d       = 4'd1;
                    data_oe_d = ~frame_bit(data_q, parity_q, 4'd1);
                    state_d   = XFER;
                end else if (cnt_q == START_LAST) begin
                    abort      = 1'b1;
                    abort_code = ERR_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                // A fall always wins over a timeout reached in the same cycle.
                if (clk_fall) begin
                    cnt_d = '0;
                    if (n_q == 4'd10) begin
                        if (!data_sync) begin
                            state_d = WAIT_IDLE;
                        end else begin
                            abort      = 1'b1;
                            abort_code = ERR_NOACK;
                        end
                    end else begin
                        n_d       = n_q + 4'd1;
                        data_oe_d = ~frame_bit(data_q, parity_q, n_q + 4'd1);
                    end
                end else if (cnt_q == EDGE_LAST) begin
                    abort      = 1'b1;
                    abort_code = ERR_EDGE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                data_oe_d = 1'b0;
                if (clk_sync && data_sync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == EDGE_LAST) begin
                    abort      = 1'b1;
                    abort_code = ERR_EDGE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // err is registered, so it is high during the single ERR cycle.
        if (abort) begin
            state_d    = ERR;
            cnt_d      = '0;
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
            err_d      = 1'b1;
            err_code_d = abort_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= 4'd0;
            data_q     <= 8'h00;
            parity_q   <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with shortened timing: a PS/2 device model drives the
// open-drain bus and checks each host bit against a scoreboard filled at send.
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int ST   = 2000;
    localparam int ET   = 300;
    localparam int HALF = 25;   // device clock half period, in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, err;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST),
        .EDGE_TIMEOUT   (ET)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         done_cnt = 0;
    int         err_cnt = 0;
    int         err_cyc = 0;
    logic [1:0] err_code_seen = 2'b00;
    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (err) begin
            err_cnt       = err_cnt + 1;
            err_cyc       = cyc;
            err_code_seen = err_code;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    bit exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        check("ready_before_send", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(($countones(b) % 2) == 0);   // odd parity bit
        exp_q.push_back(1'b1);                       // stop: line released
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    // Device side of one frame: measures the inhibit, then clocks n_edges
    // falling/rising pairs, sampling the host bit at each rising edge.
    task automatic dev_frame(input int n_edges, input bit ack, input bit poke,
                             output int req_cyc, output int last_fall_cyc);
        int w;
        int cnt;
        bit exp_bit;
        w = 0;
        cnt = 0;
        last_fall_cyc = 0;
        while (!ps2_clk_oe && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("inhibit_start", ps2_clk_oe, 1);
        while (ps2_clk_oe && cnt < INH + 100) begin
            cnt++;
            @(negedge clk);
        end
        check("inhibit_len", cnt, INH);
        check("request_data_oe", ps2_data_oe, 1);
        check("start_bit_low", ps2_data_in, 0);
        req_cyc = cyc;
        repeat (5) @(negedge clk);
        for (int e = 1; e <= n_edges; e++) begin
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            if (poke && e == 3) begin
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_clk_low = 1'b0;
            if (e <= 10) begin
                check("scoreboard_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_bit = exp_q.pop_front();
                    check($sformatf("frame_bit%0d", e), ps2_data_in, exp_bit);
                end
            end
            if (e == 10 && ack) begin
                repeat (3) @(negedge clk);
                dev_data_low = 1'b1;
                repeat (HALF - 3) @(negedge clk);
            end else if (e == 11 && ack) begin
                repeat (3) @(negedge clk);
                dev_data_low = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic wait_cnt(input bit want_err, input int base, input int budget, output bit found);
        int i;
        found = 1'b0;
        i = 0;
        while (!found && i < budget) begin
            @(negedge clk);
            #1;
            i++;
            if ((want_err ? err_cnt : done_cnt) > base) found = 1'b1;
        end
    endtask

    task automatic run_ok(input logic [7:0] b, input bit poke);
        int rc, lf, bd, be;
        bit found;
        bd = done_cnt;
        be = err_cnt;
        send(b);
        dev_frame(11, 1'b1, poke, rc, lf);
        wait_cnt(1'b0, bd, 50, found);
        check($sformatf("done_seen_%02h", b), found, 1);
        repeat (5) @(negedge clk);
        check($sformatf("done_once_%02h", b), done_cnt - bd, 1);
        check($sformatf("no_err_%02h", b), err_cnt - be, 0);
        check($sformatf("scoreboard_drained_%02h", b), exp_q.size(), 0);
        check($sformatf("idle_after_%02h", b), tx_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rc, lf, bd, be, rises;
        bit  found;

        repeat (3) @(negedge clk);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", tx_ready, 1);
        check("busy_after_rst", busy, 0);

        run_ok(8'hED, 1'b0);
        run_ok(8'hFF, 1'b0);

        // Busy gating: a second request mid-frame must not start another frame.
        run_ok(8'h01, 1'b1);
        rises = 0;
        for (int i = 0; i < 3 * INH; i++) begin
            @(negedge clk);
            if (ps2_clk_oe) rises++;
        end
        check("no_second_frame", rises, 0);

        // Device never clocks.
        be = err_cnt;
        send(8'h5A);
        dev_frame(0, 1'b0, 1'b0, rc, lf);
        wait_cnt(1'b1, be, ST + 50, found);
        check("start_timeout_seen", found, 1);
        check("start_timeout_cycles", err_cyc - rc, ST);
        check("start_timeout_code", err_code_seen, 2'b01);
        @(negedge clk);
        check("start_to_clk_oe", ps2_clk_oe, 0);
        check("start_to_data_oe", ps2_data_oe, 0);
        check("start_to_ready", tx_ready, 1);
        exp_q.delete();

        // Device stops after the 5th falling edge.
        be = err_cnt;
        send(8'h33);
        dev_frame(5, 1'b0, 1'b0, rc, lf);
        wait_cnt(1'b1, be, ET + 100, found);
        check("edge_timeout_seen", found, 1);
        check("edge_timeout_cycles", err_cyc - lf, ET + 3);  // 3 = sync + detect
        check("edge_timeout_code", err_code_seen, 2'b10);
        exp_q.delete();
        repeat (3) @(negedge clk);

        // Device leaves data high on the 11th edge.
        bd = done_cnt;
        be = err_cnt;
        send(8'hED);
        dev_frame(11, 1'b0, 1'b0, rc, lf);
        wait_cnt(1'b1, be, 50, found);
        check("noack_seen", found, 1);
        check("noack_code", err_code_seen, 2'b11);
        repeat (5) @(negedge clk);
        check("noack_no_done", done_cnt - bd, 0);
        check("noack_err_once", err_cnt - be, 1);
        check("err_code_holds", err_code, 2'b11);

        // Reset while the 4th data bit (a 0, so data is pulled) is on the bus.
        bd = done_cnt;
        be = err_cnt;
        send(8'h00);
        dev_frame(4, 1'b0, 1'b0, rc, lf);
        check("d3_driven_low", ps2_data_oe, 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_clk_oe", ps2_clk_oe, 0);
        check("async_rst_data_oe", ps2_data_oe, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", tx_ready, 1);
        repeat (5) @(negedge clk);
        check("midrst_no_done", done_cnt - bd, 0);
        check("midrst_no_err", err_cnt - be, 0);
        exp_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
